gate_counter: RTL

- Downstream consumer of the gate selector. It counts rising edges of the measured signal while the selected gate window is high.
- On the gate's falling edge it latches the count as packed BCD, together with the range flag and an overflow indication, for the display/scan stage.
- Runs on one fast system clock; the gate and the measured signal are asynchronous to it and are synchronised internally.

---
 rtl/gate_counter_pkg.sv | 18 +
 rtl/gate_counter_bcd_digit.sv | 28 ++
 rtl/gate_counter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/gate_counter_pkg.sv
// Shared definitions for the gate counter: FSM state encoding, range codes
// and the decade limit used by each BCD digit.
package gate_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        LATCH = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam logic [1:0] RANGE_1HZ   = 2'b01;
    localparam logic [1:0] RANGE_10HZ  = 2'b10;
    localparam logic [1:0] RANGE_100HZ = 2'b11;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/gate_counter_bcd_digit.sv
// One decade (0-9) of the BCD counter. The carry output is combinational so
// a whole chain of digits can advance on the same clock edge.
module bcd_digit
    import gate_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       hold,
    output logic [3:0] q,
    output logic       carry
);

    // hold freezes the digit when the whole counter is saturated at all nines
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (en && !hold) begin
            q <= (q == DIGIT_MAX) ? 4'd0 : q + 4'd1;
        end
    end

    assign carry = en && (q == DIGIT_MAX);

endmodule

// File: rtl/gate_counter.sv
// Counts synchronised rising edges of sig_in while the gate window is open and
// latches the result as packed BCD with range and overflow on the gate's fall.
module gate_counter
    import gate_counter_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sig_in,
    input  logic                  gate_in,
    input  logic                  sel_ok,
    input  logic [1:0]            range_flag,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [1:0]            range_out,
    output logic                  ovf,
    output logic                  valid,
    output logic                  busy
);

    logic [SYNC_STAGES-1:0] sig_sync;
    logic [SYNC_STAGES-1:0] gate_sync;
    logic                   sig_prev;
    logic                   gate_prev;
    logic                   sig_rise;
    logic                   gate_rise;
    logic                   gate_fall;

    state_t                 state;
    state_t                 next_state;
    logic                   counter_clr;
    logic                   latch_en;
    logic                   count_en;
    logic                   saturate;
    logic                   ovf_sticky;
    logic [4*DIGITS-1:0]    count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sig_sync  <= '0;
            gate_sync <= '0;
            sig_prev  <= 1'b0;
            gate_prev <= 1'b0;
        end else begin
            sig_sync  <= {sig_sync[SYNC_STAGES-2:0], sig_in};
            gate_sync <= {gate_sync[SYNC_STAGES-2:0], gate_in};
            sig_prev  <= sig_sync[SYNC_STAGES-1];
            gate_prev <= gate_sync[SYNC_STAGES-1];
        end
    end

    assign sig_rise  = sig_sync[SYNC_STAGES-1] && !sig_prev;
    assign gate_rise = gate_sync[SYNC_STAGES-1] && !gate_prev;
    assign gate_fall = !gate_sync[SYNC_STAGES-1] && gate_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Losing sel_ok mid-window wins over a coincident gate fall: nothing is latched
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (gate_rise && sel_ok) next_state = COUNT;
            COUNT: begin
                if (!sel_ok) begin
                    next_state = CLEAR;
                end else if (gate_fall) begin
                    next_state = LATCH;
                end
            end
            LATCH:   next_state = CLEAR;
            CLEAR:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == COUNT);
        latch_en    = (state == LATCH);
        counter_clr = (state == IDLE) || (state == CLEAR);
    end

    assign count_en = (state == COUNT) && sig_rise;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic en_i;
        logic carry_i;
        if (i == 0) begin : g_first
            assign en_i = count_en;
        end else begin : g_next
            assign en_i = g_digit[i-1].carry_i;
        end
        bcd_digit u_digit (
            .clk   (clk),
            .rst   (rst),
            .clr   (counter_clr),
            .en    (en_i),
            .hold  (saturate),
            .q     (count[4*i +: 4]),
            .carry (carry_i)
        );
    end

    // A carry out of the top digit means the count is already all nines
    assign saturate = g_digit[DIGITS-1].carry_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_sticky <= 1'b0;
        end else if (state == CLEAR) begin
            ovf_sticky <= 1'b0;
        end else if (saturate) begin
            ovf_sticky <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bcd_out   <= '0;
            range_out <= 2'b00;
            ovf       <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= latch_en;
            if (latch_en) begin
                bcd_out   <= count;
                range_out <= range_flag;
                ovf       <= ovf_sticky;
            end
        end
    end

endmodule
